l1_cache: RTL and testbench
===========================

Name: l1_cache

Overview:
- Direct-mapped, write-through, write-allocate L1 data cache between the CPU load/store port and L2_cache.
- The CPU side is word-granular.
- The L2 side moves whole blocks over the existing L2 request/ready handshake: l1_cache_read/l1_cache_write held until l1_cache_ready.
- Every CPU store is merged into a full block and written through to L2, so L1 never holds dirty data.

Parameters:
DATA_WIDTH, 32, bits per word
ADDR_WIDTH, 11, word address width; must match L2_cache
CACHE_SIZE, 128, capacity in words
BLOCK_SIZE, 32, words per block; must match L2_cache
CNT_WIDTH, 16, width of hit/miss counters

Ports:
clk  in  1  clock
rst  in  1  reset; one clock domain; reset is asynchronous and active-high
cpu_addr  in  ADDR_WIDTH  word address
cpu_wdata  in  DATA_WIDTH  store data
cpu_read  in  1  load request; level, held until cpu_ready
cpu_write  in  1  store request; level, held until cpu_ready
cpu_rdata  out  DATA_WIDTH  load data; valid with cpu_ready
cpu_ready  out  1  one-cycle completion pulse
cpu_hit  out  1  high with cpu_ready when the lookup hit
l2_addr  out  ADDR_WIDTH  block address; offset bits zero
l2_wdata  out  [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]  write-through block
l2_read  out  1  block fill request
l2_write  out  1  block write request
l2_rdata  in  [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]  fill block from L2
l2_block_valid  in  1  L2 block data valid
l2_ready  in  1  L2 completion pulse
hit_count  out  CNT_WIDTH  saturating hit counter
miss_count  out  CNT_WIDTH  saturating miss counter

Behaviour:
- Geometry: lines = CACHE_SIZE/BLOCK_SIZE; offset = addr[log2(BLOCK_SIZE)-1:0]; index = next log2(lines) bits; tag = remaining bits. With defaults: 4 lines, 5-bit offset, 2-bit index, 4-bit tag.
- Reset: all outputs 0, all line valids 0, counters 0, state IDLE. Applies immediately, including mid-transaction. An abandoned L2 transaction is dropped; the top level resets L2 concurrently.
- Registered outputs only; there is no combinational path from any input to any output.
- IDLE: sample the request, ignoring inputs in any cycle where cpu_ready=1. If cpu_read and cpu_write are both high, the request is a read. On a request, latch addr, wdata and op, then go to LOOKUP.
- LOOKUP, read hit: cpu_rdata=line[offset], cpu_hit=1, cpu_ready=1 next cycle, return to IDLE, hit_count+1. Latency is request sampled at cycle 0, cpu_ready at cycle 2.
- LOOKUP, write hit: merge wdata into the line in place; drive l2_addr={tag,index,0}, l2_wdata=merged line, l2_write=1; hit_count+1; go to WRITE_THROUGH.
- LOOKUP, miss (read or write): miss_count+1; drive l2_addr={tag,index,0} and l2_read=1; go to FILL.
- FILL: hold l2_read and l2_addr until l2_ready && l2_block_valid, then install l2_rdata, the tag and valid=1.
  - Read: return word at offset with cpu_hit=0, cpu_ready=1, then IDLE.
  - Write: merge the word and launch the write-through as above, then WRITE_THROUGH.
- WRITE_THROUGH: hold l2_write, l2_addr and l2_wdata until l2_ready, then cpu_ready=1 and IDLE. cpu_hit reflects the original lookup.
- L2 handshake:
  - Request lines deassert the cycle after l2_ready is sampled.
  - At least one cycle with both l2_read and l2_write low separates consecutive L2 requests.
  - l2_read and l2_write are never high together.
- Conflict miss: the new line overwrites the old one with no write-back, since lines are never dirty.
- Counters saturate at all-ones and do not wrap.
- Any unused state encoding returns to IDLE.

Decomposition:
- Shared package cache_pkg holds:
  - state enum (IDLE, LOOKUP, FILL, WRITE_THROUGH)
  - geometry localparam functions (offset/index/tag widths, line count), also usable by L2_cache
  - block typedef [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]
- One natural sub-module, l1_tag_store: tag and valid arrays with asynchronous clear, a write port, and a compare output giving hit for (index, tag). The data array stays in l1_cache.

Test Plan:
- Cold read 0x045 (index 2, offset 5) -> l2_read with l2_addr 0x040; L2 returns block with word k = 0x1000+k -> cpu_rdata 0x1005, cpu_hit 0, miss_count 1.
- Repeat read 0x045, then read 0x05F -> each cpu_ready 2 cycles after request, cpu_hit 1, data 0x1005 and 0x101F, no L2 traffic, hit_count 2.
- Write 0xDEADBEEF to 0x046 (hit) -> one l2_write at 0x040 with word 6 = 0xDEADBEEF and other words unchanged; cpu_ready only after l2_ready; then read 0x046 hits with 0xDEADBEEF.
- Write 0x12345678 to 0x0C5 (conflicts on index 2, tag 1) -> l2_read 0x0C0, then l2_write 0x0C0 with word 5 merged; a later read of 0x045 misses.
- cpu_read and cpu_write both high at 0x045 -> treated as a read, no l2_write; assert rst while in FILL -> outputs 0 immediately, and the next read of 0x045 misses.
- Force 2^CNT_WIDTH+3 hits -> hit_count holds 0xFFFF.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache definitions: controller states, default block type and
// geometry helpers usable by both the L1 and the L2 cache.
package cache_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_BLOCK_SIZE = 32;

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        LOOKUP        = 2'd1,
        FILL          = 2'd2,
        WRITE_THROUGH = 2'd3
    } state_e;

    typedef logic [DEFAULT_BLOCK_SIZE-1:0][DEFAULT_DATA_WIDTH-1:0] block_t;

    function automatic int line_count(int cache_size, int block_size);
        return cache_size / block_size;
    endfunction

    function automatic int offset_width(int block_size);
        return $clog2(block_size);
    endfunction

    function automatic int index_width(int cache_size, int block_size);
        return $clog2(line_count(cache_size, block_size));
    endfunction

    function automatic int tag_width(int addr_width, int cache_size, int block_size);
        return addr_width - offset_width(block_size) - index_width(cache_size, block_size);
    endfunction

endpackage

// File: rtl/l1_cache_if.sv
// Bus bundles around the L1 cache: the CPU load/store port and the
// block-granular L2 request/ready port.

interface l1_cpu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11
);
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_read;
    logic                  cpu_write;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ready;
    logic                  cpu_hit;

    // The CPU issues requests; the cache answers them.
    modport master (
        output cpu_addr, cpu_wdata, cpu_read, cpu_write,
        input  cpu_rdata, cpu_ready, cpu_hit
    );
    modport slave (
        input  cpu_addr, cpu_wdata, cpu_read, cpu_write,
        output cpu_rdata, cpu_ready, cpu_hit
    );
endinterface

interface l1_l2_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int BLOCK_SIZE = 32
);
    logic [ADDR_WIDTH-1:0]                  l2_addr;
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]  l2_wdata;
    logic                                   l2_read;
    logic                                   l2_write;
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]  l2_rdata;
    logic                                   l2_block_valid;
    logic                                   l2_ready;

    // The L1 cache issues block requests; L2 answers them.
    modport master (
        output l2_addr, l2_wdata, l2_read, l2_write,
        input  l2_rdata, l2_block_valid, l2_ready
    );
    modport slave (
        input  l2_addr, l2_wdata, l2_read, l2_write,
        output l2_rdata, l2_block_valid, l2_ready
    );
endinterface

// File: rtl/l1_tag_store.sv
// Tag and valid arrays for the direct-mapped L1: one write port used on
// fills and a combinational hit compare for the pending request.
module l1_tag_store #(
    parameter int LINES   = 4,
    parameter int INDEX_W = 2,
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [INDEX_W-1:0] rd_index_i,
    input  logic [TAG_W-1:0]   rd_tag_i,
    output logic               hit_o
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [LINES];

    // Install a tag on fill; reset invalidates every line at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
            tag_q[wr_index_i]   <= wr_tag_i;
        end
    end

    assign hit_o = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped, write-through, write-allocate L1 data cache. Word-wide
// CPU port, block-wide L2 port; lines are never dirty so evictions are
// silent overwrites. Every output is driven straight from a register.
module l1_cache
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int CACHE_SIZE = 128,
    parameter int BLOCK_SIZE = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    l1_cpu_if.slave              cpu,
    l1_l2_if.master              l2,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    localparam int LINES = line_count(CACHE_SIZE, BLOCK_SIZE);
    localparam int OFF_W = offset_width(BLOCK_SIZE);
    localparam int IDX_W = index_width(CACHE_SIZE, BLOCK_SIZE);
    localparam int TAG_W = tag_width(ADDR_WIDTH, CACHE_SIZE, BLOCK_SIZE);

    typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] line_t;

    state_e                state_q, state_d;

    // Latched request
    logic [ADDR_WIDTH-1:0] req_addr_q,   req_addr_d;
    logic [DATA_WIDTH-1:0] req_wdata_q,  req_wdata_d;
    logic                  req_write_q,  req_write_d;
    logic                  lookup_hit_q, lookup_hit_d;

    // Registered outputs
    logic [DATA_WIDTH-1:0] cpu_rdata_q,  cpu_rdata_d;
    logic                  cpu_ready_q,  cpu_ready_d;
    logic                  cpu_hit_q,    cpu_hit_d;
    logic [ADDR_WIDTH-1:0] l2_addr_q,    l2_addr_d;
    line_t                 l2_wdata_q,   l2_wdata_d;
    logic                  l2_read_q,    l2_read_d;
    logic                  l2_write_q,   l2_write_d;
    logic [CNT_WIDTH-1:0]  hit_count_q,  hit_count_d;
    logic [CNT_WIDTH-1:0]  miss_count_q, miss_count_d;

    // Data array and its write port
    line_t                 data_q [LINES];
    logic                  line_we;
    line_t                 line_wdata;
    logic                  tag_we;
    logic                  tag_hit;

    logic [OFF_W-1:0]      req_off;
    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      req_tag;
    line_t                 cur_line;
    line_t                 hit_merged;
    line_t                 fill_merged;
    logic                  cpu_req;
    logic                  fill_done;
    logic                  wt_done;

    assign req_off   = req_addr_q[OFF_W-1:0];
    assign req_idx   = req_addr_q[OFF_W +: IDX_W];
    assign req_tag   = req_addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign cur_line  = data_q[req_idx];

    // Requests are ignored during the completion pulse so a held level
    // request is not taken twice.
    assign cpu_req   = (cpu.cpu_read || cpu.cpu_write) && !cpu_ready_q;
    assign fill_done = l2.l2_ready && l2.l2_block_valid;
    assign wt_done   = l2_write_q && l2.l2_ready;

    l1_tag_store #(
        .LINES   (LINES),
        .INDEX_W (IDX_W),
        .TAG_W   (TAG_W)
    ) u_tag_store (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (tag_we),
        .wr_index_i (req_idx),
        .wr_tag_i   (req_tag),
        .rd_index_i (req_idx),
        .rd_tag_i   (req_tag),
        .hit_o      (tag_hit)
    );

    // Merge the pending store word into the resident line and into the fill block
    always_comb begin
        hit_merged           = cur_line;
        hit_merged[req_off]  = req_wdata_q;
        fill_merged          = l2.l2_rdata;
        fill_merged[req_off] = req_wdata_q;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (!tag_hit) begin
                    state_d = FILL;
                end else if (req_write_q) begin
                    state_d = WRITE_THROUGH;
                end else begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                if (fill_done) begin
                    state_d = req_write_q ? WRITE_THROUGH : IDLE;
                end
            end
            WRITE_THROUGH: begin
                if (wt_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of outputs, request latch, counters and array writes
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        req_write_d  = req_write_q;
        lookup_hit_d = lookup_hit_q;
        cpu_rdata_d  = cpu_rdata_q;
        cpu_ready_d  = 1'b0;
        cpu_hit_d    = 1'b0;
        l2_addr_d    = l2_addr_q;
        l2_wdata_d   = l2_wdata_q;
        l2_read_d    = l2_read_q;
        l2_write_d   = l2_write_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        line_we      = 1'b0;
        line_wdata   = '0;
        tag_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    req_addr_d  = cpu.cpu_addr;
                    req_wdata_d = cpu.cpu_wdata;
                    // A simultaneous read and write is served as a read.
                    req_write_d = cpu.cpu_write && !cpu.cpu_read;
                end
            end
            LOOKUP: begin
                lookup_hit_d = tag_hit;
                if (tag_hit) begin
                    hit_count_d = (&hit_count_q) ? hit_count_q : hit_count_q + CNT_WIDTH'(1);
                    if (req_write_q) begin
                        line_we    = 1'b1;
                        line_wdata = hit_merged;
                        l2_addr_d  = {req_tag, req_idx, OFF_W'(0)};
                        l2_wdata_d = hit_merged;
                        l2_write_d = 1'b1;
                    end else begin
                        cpu_rdata_d = cur_line[req_off];
                        cpu_ready_d = 1'b1;
                        cpu_hit_d   = 1'b1;
                    end
                end else begin
                    miss_count_d = (&miss_count_q) ? miss_count_q : miss_count_q + CNT_WIDTH'(1);
                    l2_addr_d    = {req_tag, req_idx, OFF_W'(0)};
                    l2_read_d    = 1'b1;
                end
            end
            FILL: begin
                if (fill_done) begin
                    l2_read_d = 1'b0;
                    line_we   = 1'b1;
                    tag_we    = 1'b1;
                    if (req_write_q) begin
                        // l2_write rises one cycle later in WRITE_THROUGH,
                        // leaving an idle cycle between the two L2 requests.
                        line_wdata = fill_merged;
                        l2_wdata_d = fill_merged;
                    end else begin
                        line_wdata  = l2.l2_rdata;
                        cpu_rdata_d = l2.l2_rdata[req_off];
                        cpu_ready_d = 1'b1;
                    end
                end
            end
            WRITE_THROUGH: begin
                if (!l2_write_q) begin
                    l2_write_d = 1'b1;
                end else if (l2.l2_ready) begin
                    l2_write_d  = 1'b0;
                    cpu_ready_d = 1'b1;
                    cpu_hit_d   = lookup_hit_q;
                end
            end
            default: ;
        endcase
    end

    // Output, request and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_write_q  <= 1'b0;
            lookup_hit_q <= 1'b0;
            cpu_rdata_q  <= '0;
            cpu_ready_q  <= 1'b0;
            cpu_hit_q    <= 1'b0;
            l2_addr_q    <= '0;
            l2_wdata_q   <= '0;
            l2_read_q    <= 1'b0;
            l2_write_q   <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            req_write_q  <= req_write_d;
            lookup_hit_q <= lookup_hit_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_ready_q  <= cpu_ready_d;
            cpu_hit_q    <= cpu_hit_d;
            l2_addr_q    <= l2_addr_d;
            l2_wdata_q   <= l2_wdata_d;
            l2_read_q    <= l2_read_d;
            l2_write_q   <= l2_write_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Data array write
    always_ff @(posedge clk) begin
        // NOTE: the data array has no reset; the cleared valid bits in the tag
        // store make stale contents unreachable.
        if (line_we) begin
            data_q[req_idx] <= line_wdata;
        end
    end

    assign cpu.cpu_rdata = cpu_rdata_q;
    assign cpu.cpu_ready = cpu_ready_q;
    assign cpu.cpu_hit   = cpu_hit_q;
    assign l2.l2_addr    = l2_addr_q;
    assign l2.l2_wdata   = l2_wdata_q;
    assign l2.l2_read    = l2_read_q;
    assign l2.l2_write   = l2_write_q;
    assign hit_count     = hit_count_q;
    assign miss_count    = miss_count_q;

endmodule

// File: tb/tb_l1_cache.sv
// Self-checking bench for l1_cache: directed scenarios followed by random
// loads/stores, checked against a word-level memory image and a per-index
// tag table.
module tb_l1_cache;

    localparam int DW    = 32;
    localparam int AW    = 11;
    localparam int CS    = 128;
    localparam int BS    = 32;
    localparam int CW    = 8;
    localparam int LINES = CS / BS;
    localparam int CMAX  = (1 << CW) - 1;

    typedef logic [BS-1:0][DW-1:0] blk_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    l1_cpu_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) cpu_bus ();
    l1_l2_if  #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) l2_bus ();

    l1_cache #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CACHE_SIZE (CS),
        .BLOCK_SIZE (BS),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu        (cpu_bus),
        .l2         (l2_bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference state
    logic [DW-1:0] gold   [1 << AW];
    logic [DW-1:0] l2_mem [1 << AW];
    bit            m_valid [LINES];
    int            m_tag   [LINES];
    int            m_hits;
    int            m_misses;

    // L2 model observations
    int            l2_reads  = 0;
    int            l2_writes = 0;
    int            proto_err = 0;
    int            l2_delay  = 0;
    logic [AW-1:0] last_rd_addr = '0;
    logic [AW-1:0] last_wr_addr = '0;
    blk_t          last_wr_blk  = '0;

    task automatic check(input string name, input logic [BS*DW-1:0] obs, input logic [BS*DW-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    task automatic clear_model();
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    // L2 responder: random latency, one-cycle ready pulse, protocol monitor
    initial begin
        l2_bus.l2_ready       = 1'b0;
        l2_bus.l2_block_valid = 1'b0;
        l2_bus.l2_rdata       = '0;
        forever begin
            @(negedge clk);
            if (l2_bus.l2_read && l2_bus.l2_write) proto_err++;
            if ((l2_bus.l2_read || l2_bus.l2_write) && (l2_bus.l2_addr % BS) != 0) proto_err++;
            if (l2_bus.l2_ready && (l2_bus.l2_read || l2_bus.l2_write)) proto_err++;
            if (rst) begin
                l2_bus.l2_ready       = 1'b0;
                l2_bus.l2_block_valid = 1'b0;
                l2_delay              = $urandom_range(0, 3);
            end else if (l2_bus.l2_ready) begin
                l2_bus.l2_ready       = 1'b0;
                l2_bus.l2_block_valid = 1'b0;
            end else if (l2_bus.l2_read || l2_bus.l2_write) begin
                if (l2_delay == 0) begin
                    if (l2_bus.l2_read) begin
                        for (int k = 0; k < BS; k++) l2_bus.l2_rdata[k] = l2_mem[int'(l2_bus.l2_addr) + k];
                        l2_bus.l2_block_valid = 1'b1;
                        last_rd_addr          = l2_bus.l2_addr;
                        l2_reads++;
                    end else begin
                        for (int k = 0; k < BS; k++) l2_mem[int'(l2_bus.l2_addr) + k] = l2_bus.l2_wdata[k];
                        last_wr_addr = l2_bus.l2_addr;
                        last_wr_blk  = l2_bus.l2_wdata;
                        l2_writes++;
                    end
                    l2_bus.l2_ready = 1'b1;
                    l2_delay        = $urandom_range(0, 3);
                end else begin
                    l2_delay--;
                end
            end
        end
    end

    // One CPU access, checked against the reference model
    task automatic do_op(input bit rd, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, output logic [DW-1:0] rdata_o, output bit hit_o);
        int   idx, tg, base, cyc, rd0, wr0;
        bit   exp_hit, is_read, got;
        blk_t blk;
        is_read = rd;
        idx     = (int'(addr) / BS) % LINES;
        tg      = int'(addr) / (BS * LINES);
        base    = int'(addr) - (int'(addr) % BS);
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        rd0     = l2_reads;
        wr0     = l2_writes;
        rdata_o = '0;
        hit_o   = 1'b0;

        @(negedge clk);
        cpu_bus.cpu_addr  = addr;
        cpu_bus.cpu_wdata = wd;
        cpu_bus.cpu_read  = rd;
        cpu_bus.cpu_write = wr;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            got = cpu_bus.cpu_ready;
        end
        rdata_o = cpu_bus.cpu_rdata;
        hit_o   = cpu_bus.cpu_hit;
        cpu_bus.cpu_read  = 1'b0;
        cpu_bus.cpu_write = 1'b0;

        check("cpu_ready_seen", got, 1);
        if (got) begin
            if (!is_read) gold[addr] = wd;
            check("cpu_hit", hit_o, exp_hit);
            if (is_read) check("cpu_rdata", rdata_o, gold[addr]);
            if (is_read && exp_hit) check("hit_latency", cyc, 2);
            check("l2_read_count", l2_reads - rd0, exp_hit ? 0 : 1);
            check("l2_write_count", l2_writes - wr0, is_read ? 0 : 1);
            if (!is_read) begin
                for (int k = 0; k < BS; k++) blk[k] = gold[base + k];
                check("wt_block", last_wr_blk, blk);
                check("wt_addr", last_wr_addr, base);
            end
        end

        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        if (exp_hit) begin
            if (m_hits < CMAX) m_hits++;
        end else begin
            if (m_misses < CMAX) m_misses++;
        end

        @(posedge clk);
        #1;
        check("ready_pulse_width", cpu_bus.cpu_ready, 0);
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_misses);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cpu_bus.cpu_read  = 1'b0;
        cpu_bus.cpu_write = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1, "watchdog expired");
    end

    // Directed and random stimulus
    initial begin
        logic [DW-1:0] r;
        bit            h;
        int            cyc;

        rst               = 1'b1;
        cpu_bus.cpu_addr  = '0;
        cpu_bus.cpu_wdata = '0;
        cpu_bus.cpu_read  = 1'b0;
        cpu_bus.cpu_write = 1'b0;
        for (int a = 0; a < (1 << AW); a++) l2_mem[a] = $urandom;
        for (int k = 0; k < BS; k++) l2_mem['h40 + k] = 32'h1000 + k;
        for (int a = 0; a < (1 << AW); a++) gold[a] = l2_mem[a];
        clear_model();

        #1;
        check("reset_cpu_ready", cpu_bus.cpu_ready, 0);
        check("reset_l2_read", l2_bus.l2_read, 0);
        check("reset_l2_write", l2_bus.l2_write, 0);
        check("reset_hit_count", hit_count, 0);
        check("reset_miss_count", miss_count, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Cold miss, then hits in the same block
        do_op(1'b1, 1'b0, 11'h045, '0, r, h);
        check("cold_rdata", r, 32'h1005);
        check("cold_fill_addr", last_rd_addr, 11'h040);
        check("cold_miss_count", miss_count, 1);
        do_op(1'b1, 1'b0, 11'h045, '0, r, h);
        check("rehit_rdata", r, 32'h1005);
        do_op(1'b1, 1'b0, 11'h05F, '0, r, h);
        check("hit_last_word", r, 32'h101F);
        check("hit_count_two", hit_count, 2);

        // Write hit, write-through, read back
        do_op(1'b0, 1'b1, 11'h046, 32'hDEADBEEF, r, h);
        check("wr_hit_flag", h, 1);
        check("wr_hit_l2_addr", last_wr_addr, 11'h040);
        check("wr_hit_word6", last_wr_blk[6], 32'hDEADBEEF);
        check("wr_hit_word7", last_wr_blk[7], 32'h1007);
        do_op(1'b1, 1'b0, 11'h046, '0, r, h);
        check("readback_rdata", r, 32'hDEADBEEF);

        // Conflict write miss on index 2, then old block misses
        do_op(1'b0, 1'b1, 11'h0C5, 32'h12345678, r, h);
        check("conflict_fill_addr", last_rd_addr, 11'h0C0);
        check("conflict_wt_addr", last_wr_addr, 11'h0C0);
        check("conflict_wt_word5", last_wr_blk[5], 32'h12345678);
        do_op(1'b1, 1'b0, 11'h045, '0, r, h);
        check("conflict_old_miss", h, 0);

        // Simultaneous read and write is a read
        do_op(1'b1, 1'b1, 11'h045, 32'hFFFFFFFF, r, h);
        check("both_high_rdata", r, 32'h1005);

        // Reset while a fill is outstanding
        @(negedge clk);
        cpu_bus.cpu_addr = 11'h100;
        cpu_bus.cpu_read = 1'b1;
        cyc = 0;
        while (!l2_bus.l2_read && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("fill_entered", l2_bus.l2_read, 1);
        rst = 1'b1;
        #1;
        check("midfill_l2_read", l2_bus.l2_read, 0);
        check("midfill_l2_addr", l2_bus.l2_addr, 0);
        check("midfill_cpu_rdata", cpu_bus.cpu_rdata, 0);
        check("midfill_cpu_ready", cpu_bus.cpu_ready, 0);
        check("midfill_hit_count", hit_count, 0);
        check("midfill_miss_count", miss_count, 0);
        do_reset();
        do_op(1'b1, 1'b0, 11'h045, '0, r, h);
        check("post_reset_miss", h, 0);

        // Random mix of loads and stores over four tags
        for (int n = 0; n < 150; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            do_op((sel < 6) || (sel == 9), sel >= 6, 11'($urandom_range(0, 511)), $urandom, r, h);
        end

        // Hit counter saturation
        do_reset();
        do_op(1'b1, 1'b0, 11'h000, '0, r, h);
        for (int n = 0; n < (1 << CW) + 3; n++) begin
            do_op(1'b1, 1'b0, 11'h000, '0, r, h);
        end
        check("hit_count_saturated", hit_count, CMAX);
        check("miss_count_after_sat", miss_count, 1);

        check("l2_protocol_errors", proto_err, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
